// File: rtl/tmr_scrub_ctrl.sv
// ---------------------------------------------------------------------------
// tmr_scrub_ctrl
//   Scrub controller for one triplicated register group. It watches the three
//   register copies, detects a disagreement, forces the bitwise majority back
//   into all copies, verifies the repair, and counts and flags faults. When
//   nothing is wrong it runs a preventive scrub every SCRUB_PERIOD idle cycles.
//
// Ports
//   clk        in   rising-edge clock (same as the register copies)
//   rst        in   asynchronous active-high reset
//   copy_0..2  in   Q outputs of the three register copies
//   err_clr    in   pulse: clear err_cnt, multi_flt and fail (leaves FAIL)
//   scrub_data out  bitwise majority of the copies (combinational)
//   resync     out  all three copies load scrub_data at the next edge
//   fault_mask out  copies that disagreed at the last detection
//   err_cnt    out  saturating count of detected mismatches
//   multi_flt  out  sticky: two or more copies wrong in one detection
//   fail       out  sticky: repair failed MAX_RETRY times
//   busy       out  controller is not idle
// ---------------------------------------------------------------------------
module tmr_scrub_ctrl #(
    parameter int WIDTH        = 1,
    parameter int CNT_W        = 8,
    parameter int SCRUB_PERIOD = 16,
    parameter int MAX_RETRY    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] copy_0,
    input  logic [WIDTH-1:0] copy_1,
    input  logic [WIDTH-1:0] copy_2,
    input  logic             err_clr,
    output logic [WIDTH-1:0] scrub_data,
    output logic             resync,
    output logic [2:0]       fault_mask,
    output logic [CNT_W-1:0] err_cnt,
    output logic             multi_flt,
    output logic             fail,
    output logic             busy
);

    localparam int TMR_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(SCRUB_PERIOD - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCRUB  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [TMR_W-1:0] timer, timer_d;
    logic [RTY_W-1:0] retry, retry_d;
    logic [2:0]       mask_d;
    logic [CNT_W-1:0] cnt_d, cnt_base;
    logic             multi_d, fail_d, resync_d, busy_d;

    // Voting and per-copy disagreement
    logic [2:0] wrong;
    logic       mism, multi_new;

    assign scrub_data = (copy_0 & copy_1) | (copy_1 & copy_2) | (copy_0 & copy_2);
    assign wrong      = {|(copy_2 ^ scrub_data), |(copy_1 ^ scrub_data), |(copy_0 ^ scrub_data)};
    assign mism       = |wrong;
    assign multi_new  = (wrong[0] & wrong[1]) | (wrong[1] & wrong[2]) | (wrong[0] & wrong[2]);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            retry      <= '0;
            resync     <= 1'b0;
            fault_mask <= '0;
            err_cnt    <= '0;
            multi_flt  <= 1'b0;
            fail       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_d;
            retry      <= retry_d;
            resync     <= resync_d;
            fault_mask <= mask_d;
            err_cnt    <= cnt_d;
            multi_flt  <= multi_d;
            fail       <= fail_d;
            busy       <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (mism || timer == TMR_LAST) state_nx = ST_SCRUB;
            end
            ST_SCRUB: state_nx = ST_VERIFY;
            ST_VERIFY: begin
                if (!mism)                              state_nx = ST_IDLE;
                else if (retry + 1'b1 == RTY_LIMIT)     state_nx = ST_FAIL;
                else                                    state_nx = ST_SCRUB;
            end
            ST_FAIL: begin
                if (err_clr) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output / datapath next values. The clear is applied before a coincident
    // detection, so the detection's count and multi flag start from zero.
    always_comb begin
        cnt_base = err_clr ? '0 : err_cnt;
        timer_d  = '0;
        retry_d  = retry;
        mask_d   = fault_mask;
        cnt_d    = cnt_base;
        multi_d  = err_clr ? 1'b0 : multi_flt;
        unique case (state)
            ST_IDLE: begin
                if (mism) begin
                    mask_d  = wrong;
                    cnt_d   = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
                    multi_d = multi_d | multi_new;
                    retry_d = '0;
                end else if (timer != TMR_LAST) begin
                    timer_d = timer + 1'b1;
                end
            end
            ST_VERIFY: begin
                if (mism) retry_d = retry + 1'b1;
            end
            default: ;
        endcase
        // Registered from the next state so each flag lines up with its state
        fail_d   = (state_nx == ST_FAIL) ? 1'b1 : (err_clr ? 1'b0 : fail);
        resync_d = (state_nx == ST_SCRUB);
        busy_d   = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
module tb_tmr_scrub_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] cp [3];
    logic         err_clr;
    logic [W-1:0] scrub_data;
    logic         resync;
    logic [2:0]   fault_mask;
    logic [7:0]   err_cnt;
    logic         multi_flt, fail, busy;

    int checks = 0;
    int errors = 0;

    logic [2:0] stuck;
    logic [7:0] model_cnt;
    logic       model_multi;

    typedef struct packed {
        logic [2:0] mask;
        logic [7:0] cnt;
        logic       multi;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    tmr_scrub_ctrl #(.WIDTH(W), .CNT_W(8), .SCRUB_PERIOD(16), .MAX_RETRY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .copy_0     (cp[0]),
        .copy_1     (cp[1]),
        .copy_2     (cp[2]),
        .err_clr    (err_clr),
        .scrub_data (scrub_data),
        .resync     (resync),
        .fault_mask (fault_mask),
        .err_cnt    (err_cnt),
        .multi_flt  (multi_flt),
        .fail       (fail),
        .busy       (busy)
    );

    function automatic logic [W-1:0] maj3(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) m[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        return m;
    endfunction

    // One clock; register copies that are not stuck load the majority if
    // resync was high during the cycle that just ended.
    task automatic tick();
        logic         r;
        logic [W-1:0] m;
        r = resync;
        m = maj3(cp[0], cp[1], cp[2]);
        @(posedge clk);
        #1;
        if (r) for (int k = 0; k < 3; k++) if (!stuck[k]) cp[k] = m;
    endtask

    // Drive copy values and push the detection the bench expects.
    task automatic inject(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
        logic [W-1:0] m;
        exp_t         e;
        cp[0] = a; cp[1] = b; cp[2] = c;
        m = maj3(a, b, c);
        e.mask = {c != m, b != m, a != m};
        model_cnt   = (model_cnt == 8'hFF) ? 8'hFF : model_cnt + 8'd1;
        model_multi = model_multi | (int'(e.mask[0]) + int'(e.mask[1]) + int'(e.mask[2]) >= 2);
        e.cnt   = model_cnt;
        e.multi = model_multi;
        sb.push_back(e);
    endtask

    task automatic expect_detect(string name);
        exp_t e;
        for (int i = 0; i < 8 && resync !== 1'b1; i++) tick();
        checks++;
        if (resync !== 1'b1) begin
            errors++;
            $display("FAIL %s resync timeout: got %b want 1", name, resync);
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (fault_mask !== e.mask || err_cnt !== e.cnt || multi_flt !== e.multi) begin
                errors++;
                $display("FAIL %s detect: got mask=%b cnt=%0d multi=%b want mask=%b cnt=%0d multi=%b",
                         name, fault_mask, err_cnt, multi_flt, e.mask, e.cnt, e.multi);
            end
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        model_cnt = '0;
        model_multi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; err_clr = 1'b0; stuck = '0;
        cp[0] = '0; cp[1] = '0; cp[2] = '0;
        model_cnt = '0; model_multi = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({resync, fault_mask, err_cnt, multi_flt, fail, busy} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got resync=%b mask=%b cnt=%0d multi=%b fail=%b busy=%b want all 0",
                     resync, fault_mask, err_cnt, multi_flt, fail, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_periodic();
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (resync !== ((i == 16) || (i == 34))) begin
                errors++;
                $display("FAIL periodic cycle %0d: resync=%b want %b", i, resync, (i == 16) || (i == 34));
            end
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL periodic err_cnt: got %0d want 0", err_cnt);
        end
    endtask

    task automatic test_single_fault();
        inject(4'b0000, 4'b0001, 4'b0000);
        expect_detect("single");
        tick();
        checks++;
        if (busy !== 1'b1 || resync !== 1'b0) begin
            errors++;
            $display("FAIL single verify: busy=%b resync=%b want 1 0", busy, resync);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || fail !== 1'b0 || cp[1] !== 4'b0000) begin
            errors++;
            $display("FAIL single repaired: busy=%b fail=%b copy1=%b want 0 0 0000", busy, fail, cp[1]);
        end
    endtask

    task automatic test_multi_fault();
        inject(4'b0001, 4'b0010, 4'b0000);
        #1;
        checks++;
        if (scrub_data !== 4'b0000) begin
            errors++;
            $display("FAIL multi scrub_data: got %b want 0000", scrub_data);
        end
        expect_detect("multi");
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || multi_flt !== 1'b1) begin
            errors++;
            $display("FAIL multi after: busy=%b multi=%b want 0 1", busy, multi_flt);
        end
    endtask

    task automatic test_stuck_fail();
        pulse_clr();
        stuck = 3'b100;
        inject(4'b0000, 4'b0000, 4'b0001);
        expect_detect("stuck");
        tick();
        tick();
        checks++;
        if (resync !== 1'b1) begin
            errors++;
            $display("FAIL stuck rescrub: resync=%b want 1", resync);
        end
        tick();
        tick();
        checks++;
        if (fail !== 1'b1 || busy !== 1'b1 || err_cnt !== model_cnt || resync !== 1'b0) begin
            errors++;
            $display("FAIL stuck fail state: fail=%b busy=%b cnt=%0d resync=%b want 1 1 %0d 0",
                     fail, busy, err_cnt, resync, model_cnt);
        end
        repeat (3) tick();
        checks++;
        if (fail !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stuck hold: fail=%b busy=%b want 1 1", fail, busy);
        end
        stuck = '0;
        cp[0] = '0; cp[1] = '0; cp[2] = '0;
        pulse_clr();
        checks++;
        if (fail !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stuck clear: fail=%b busy=%b cnt=%0d want 0 0 0", fail, busy, err_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [W-1:0] v [3];
        pulse_clr();
        for (int n = 0; n < 256; n++) begin
            v[0] = '0; v[1] = '0; v[2] = '0;
            v[$urandom_range(0, 2)][$urandom_range(0, W - 1)] = 1'b1;
            inject(v[0], v[1], v[2]);
            expect_detect("saturate");
            repeat (2) tick();
        end
        checks++;
        if (err_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturate final: got %0d want 255", err_cnt);
        end
    endtask

    task automatic test_clr_collide();
        err_clr = 1'b1;
        model_cnt = '0;
        model_multi = 1'b0;
        inject(4'b0100, 4'b1000, 4'b0000);
        tick();
        err_clr = 1'b0;
        expect_detect("collide");
        repeat (2) tick();
    endtask

    task automatic test_reset_in_scrub();
        inject(4'b0000, 4'b0000, 4'b0010);
        expect_detect("rst_scrub");
        #2 rst = 1'b1;
        #1;
        checks++;
        if (resync !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_scrub async: resync=%b busy=%b cnt=%0d want 0 0 0", resync, busy, err_cnt);
        end
        cp[0] = '0; cp[1] = '0; cp[2] = '0;
        model_cnt = '0; model_multi = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || err_cnt !== 8'd0 || resync !== 1'b0 || fault_mask !== 3'b000) begin
            errors++;
            $display("FAIL rst_scrub release: busy=%b cnt=%0d resync=%b mask=%b want 0 0 0 000",
                     busy, err_cnt, resync, fault_mask);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_single_fault();
        test_multi_fault();
        test_stuck_fail();
        test_saturate();
        test_clr_collide();
        test_reset_in_scrub();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
